// File: rtl/counter_pkg.sv
// Shared constants for the down_counter8 slice: seven-segment patterns and count modes.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package counter_pkg;

    localparam int unsigned Q_W   = 3;
    localparam int unsigned SEG_W = 7;

    localparam logic [Q_W-1:0] Q_MAX = 3'd7;

    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_STOP = 1'b1;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 3-bit value to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module seg7_decode
    import counter_pkg::*;
(
    input  logic [Q_W-1:0]   value,
    output logic [SEG_W-1:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (value)
            3'd0: seg = SEG_0;
            3'd1: seg = SEG_1;
            3'd2: seg = SEG_2;
            3'd3: seg = SEG_3;
            3'd4: seg = SEG_4;
            3'd5: seg = SEG_5;
            3'd6: seg = SEG_6;
            3'd7: seg = SEG_7;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/down_counter8.sv
// 3-bit down counter advanced by a DIV_N-cycle prescaler, with wrap/stop modes and load.
// Define DOWN_COUNTER8_DISPLAY_EN to drive oDisplay from the seven-segment decoder.
module down_counter8
    import counter_pkg::*;
#(
    parameter int unsigned DIV_N = 100000000
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             iEn,
    input  logic             iLoad,
    input  logic [2:0]       iData,
    input  logic             iMode,
    output logic [2:0]       oQ,
    output logic             oBorrow,
    output logic             oZero,
    output logic [6:0]       oDisplay
);

    localparam int unsigned     PRE_W    = (DIV_N > 1) ? $clog2(DIV_N) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV_N - 1);

    logic [PRE_W-1:0] pre;
    logic             tick;
    logic [Q_W-1:0]   q;
    logic             borrow;

    assign tick = (pre == PRE_LAST);

    // Free-running prescaler; a load restarts the interval so the next tick is a full period away.
    always_ff @(posedge CLK) begin
        if (!rst_n || iLoad || tick) begin
            pre <= '0;
        end else begin
            pre <= pre + PRE_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            q      <= '0;
            borrow <= 1'b0;
        end else if (iLoad) begin
            q      <= iData;
            borrow <= 1'b0;
        end else if (tick && iEn) begin
            if (q != '0) begin
                q      <= q - Q_W'(1);
                borrow <= 1'b0;
            end else if (iMode == MODE_WRAP) begin
                q      <= Q_MAX;
                borrow <= 1'b1;
            end else begin
                borrow <= 1'b0;
            end
        end else begin
            borrow <= 1'b0;
        end
    end

    assign oQ      = q;
    assign oBorrow = borrow;
    assign oZero   = (q == '0);

`ifdef DOWN_COUNTER8_DISPLAY_EN
    seg7_decode u_seg7_decode (
        .value (q),
        .seg   (oDisplay)
    );
`else
    assign oDisplay = SEG_BLANK;
`endif

endmodule

// File: doc/down_counter8.md
DOWN_COUNTER8 -- requirements
Module: down_counter8

Interface
REQ-001 Parameter DIV_N, default 100000000, number of CLK cycles per count tick (legal range 1 to 2^27).
REQ-002 Port CLK, input, 1 bit, sole system clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit, synchronous active-low reset.
REQ-004 Port iEn, input, 1 bit, count enable; when 0, ticks are ignored and the counter holds.
REQ-005 Port iLoad, input, 1 bit, synchronous parallel-load strobe.
REQ-006 Port iData, input, 3 bits, load value.
REQ-007 Port iMode, input, 1 bit: 0 = wrap 0->7, 1 = stop at 0.
REQ-008 Port oQ, output, 3 bits, current count.
REQ-009 Port oBorrow, output, 1 bit, one-CLK pulse on a 0->7 wrap.
REQ-010 Port oZero, output, 1 bit, high while oQ == 0.
REQ-011 Port oDisplay, output, 7 bits, seven-segment pattern {g,f,e,d,c,b,a}, active-low.

Function
REQ-012 Prescaler counts CLK cycles from 0 to DIV_N-1, then returns to 0; the internal tick is high for the single cycle in which the prescaler equals DIV_N-1.
REQ-013 With DIV_N = 1, the tick is high every cycle.
REQ-014 Priority per edge: reset > load > tick-count > hold.
REQ-015 iLoad=1: oQ <= iData at the next edge, independent of tick and iEn; prescaler cleared to 0; oBorrow <= 0.
REQ-016 Tick with iEn=1 and oQ != 0: oQ <= oQ-1.
REQ-017 Tick with iEn=1, oQ == 0, iMode=0: oQ <= 7; oBorrow = 1 for exactly that following cycle.
REQ-018 Tick with iEn=1, oQ == 0, iMode=1: oQ holds at 0; oBorrow stays 0.
REQ-019 iEn=0: prescaler keeps running; oQ holds.
REQ-020 oBorrow is 0 in every cycle not covered by REQ-017.
REQ-021 oZero is combinational from oQ, with no added latency.
REQ-022 oDisplay is combinational from oQ: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
REQ-023 iMode changes take effect at the next tick; no other state is disturbed.

Reset
REQ-024 rst_n=0 at an edge: oQ=0, prescaler=0, oBorrow=0; as a result oZero=1 and oDisplay=1000000.
REQ-025 Reset asserted mid-count or during iLoad overrides all other inputs in that cycle.
REQ-026 The first tick after reset release occurs DIV_N cycles after the first edge with rst_n=1.

Configuration
REQ-027 Macro DOWN_COUNTER8_DISPLAY_EN defined: oDisplay is driven per REQ-022.
REQ-028 Macro DOWN_COUNTER8_DISPLAY_EN undefined: the decoder is not instantiated and oDisplay is constant 1111111 (all segments off); all other behaviour is unchanged.

Structure
REQ-029 Shared package counter_pkg holds:
- the eight segment-pattern constants (SEG_0..SEG_7, 7 bits each);
- the SEG_BLANK constant (1111111);
- the mode constants MODE_WRAP=0 and MODE_STOP=1.
REQ-030 One sub-module, seg7_decode: 3-bit in, 7-bit out, purely combinational, instantiated only under DOWN_COUNTER8_DISPLAY_EN.
REQ-031 Prescaler and counter logic reside in down_counter8 itself, without a separate divider module.

Verification (DIV_N=4 unless stated)
REQ-032 Reset then iEn=1, iMode=0: oQ sequence 0,7,6,...,1,0,7, with one change every 4 CLK; oBorrow is one cycle high at each 0->7 step.
REQ-033 iLoad=1, iData=5 mid-interval: next edge oQ=5, and the next decrement to 4 lands exactly 4 CLK later.
REQ-034 iMode=1, load 2, iEn=1: oQ goes 2,1,0 and then stays 0 for 20 CLK; oZero=1 and oBorrow=0 throughout the hold.
REQ-035 iEn=0 for 12 CLK at oQ=3: oQ stays 3; after re-enabling, the next decrement aligns to the free-running prescaler.
REQ-036 rst_n=0 coincident with iLoad=1 and a tick at oQ=6: next edge oQ=0, oDisplay=1000000, oBorrow=0.
REQ-037 DIV_N=1, macro undefined: oQ decrements every cycle and oDisplay stays at 1111111.
